// File: rtl/conv_pkg.sv
// Shared types and address helpers for the convolution MAC sequencer.
package conv_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StBiasRd,
    StBiasWr,
    StMac,
    StStore,
    StRelu,
    StDone
  } state_e;

  // Input feature-map address of tap (ic,kr,kc) for output position (r,c).
  function automatic int unsigned in_addr(input int unsigned ic, input int unsigned r,
                                          input int unsigned c, input int unsigned kr,
                                          input int unsigned kc, input int unsigned in_w);
    return ic * in_w * in_w + (r + kr) * in_w + (c + kc);
  endfunction

  // Weight address of tap (ic,kr,kc) for output channel oc.
  function automatic int unsigned w_addr(input int unsigned oc, input int unsigned ic,
                                         input int unsigned kr, input int unsigned kc,
                                         input int unsigned in_ch, input int unsigned k);
    return ((oc * in_ch + ic) * k + kr) * k + kc;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply with a 32-bit wrapping accumulator; clear has priority over enable.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int unsigned OP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [OP_W-1:0]   i_a,
  input  logic [OP_W-1:0]   i_b,
  output logic [ACC_W-1:0]  o_sum
);

  logic signed [ACC_W-1:0] w_a;
  logic signed [ACC_W-1:0] w_b;
  logic signed [ACC_W-1:0] w_prod;
  logic        [ACC_W-1:0] r_acc;

  assign w_a    = ACC_W'($signed(i_a));
  assign w_b    = ACC_W'($signed(i_b));
  assign w_prod = w_a * w_b;
  // Running sum including the product currently on the operand inputs.
  assign o_sum  = r_acc + w_prod;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Walks output channels and positions, running a kernel-window MAC per position and
// strobing bias/store/relu/done into the downstream result file.
module conv_mac_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IN_W      = 10,
  parameter int unsigned K         = 3,
  parameter int unsigned IN_CH     = 1,
  parameter int unsigned OUT_CH    = 4,
  parameter int unsigned DATA_W    = conv_pkg::DATA_W,
  parameter int unsigned IN_ADDR_W = 10,
  parameter int unsigned W_ADDR_W  = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic [IN_ADDR_W-1:0] o_in_rd_addr,
  input  logic [DATA_W-1:0]    i_in_data,
  output logic [W_ADDR_W-1:0]  o_w_rd_addr,
  input  logic [DATA_W-1:0]    i_w_data,
  output logic [3:0]           o_b_rd_addr,
  input  logic [31:0]          i_b_data,
  output logic                 o_bias_init,
  output logic [31:0]          o_bias,
  output logic                 o_store,
  output logic [9:0]           o_addr,
  output logic [31:0]          o_value,
  output logic                 o_relu,
  output logic [3:0]           o_out_c,
  output logic                 o_done
);

  localparam int unsigned OUT_W = IN_W - K + 1;
  localparam int unsigned T     = IN_CH * K * K;

  state_e      r_state;
  logic [3:0]  r_oc;
  logic [5:0]  r_r;
  logic [5:0]  r_c;
  logic [15:0] r_t;
  logic [7:0]  r_ic;
  logic [7:0]  r_kr;
  logic [7:0]  r_kc;
  logic        r_busy;
  logic        r_bias_init;
  logic [31:0] r_bias;
  logic        r_store;
  logic [9:0]  r_addr;
  logic [31:0] r_value;
  logic        r_relu;
  logic [3:0]  r_out_c;
  logic        r_done;

  logic                 w_last_tap;
  logic                 w_last_pos;
  logic                 w_mac_clr;
  logic                 w_mac_en;
  logic [ACC_W-1:0]     w_sum;
  logic [IN_ADDR_W-1:0] w_in_addr;
  logic [W_ADDR_W-1:0]  w_w_addr;

  assign w_last_tap = (r_t == 16'(T));
  assign w_last_pos = (r_r == 6'(OUT_W - 1)) && (r_c == 6'(OUT_W - 1));
  // Tap t's operands arrive at t+1, so t=0 only clears and t=T only accumulates.
  assign w_mac_clr  = (r_state == StMac) && (r_t == '0);
  assign w_mac_en   = (r_state == StMac) && (r_t != '0);

  always_comb begin
    w_in_addr = '0;
    w_w_addr  = '0;
    if (r_state == StMac && !w_last_tap) begin
      w_in_addr = IN_ADDR_W'(in_addr(32'(r_ic), 32'(r_r), 32'(r_c), 32'(r_kr), 32'(r_kc), IN_W));
      w_w_addr  = W_ADDR_W'(w_addr(32'(r_oc), 32'(r_ic), 32'(r_kr), 32'(r_kc), IN_CH, K));
    end
  end

  conv_mac_unit #(
    .OP_W (DATA_W)
  ) u_mac (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (i_in_data),
    .i_b   (i_w_data),
    .o_sum (w_sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_oc        <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_t         <= '0;
      r_ic        <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_busy      <= 1'b0;
      r_bias_init <= 1'b0;
      r_bias      <= '0;
      r_store     <= 1'b0;
      r_addr      <= '0;
      r_value     <= '0;
      r_relu      <= 1'b0;
      r_out_c     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_bias_init <= 1'b0;
      r_store     <= 1'b0;
      r_relu      <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StBiasRd;
            r_busy  <= 1'b1;
            r_oc    <= '0;
            r_r     <= '0;
            r_c     <= '0;
          end
        end
        StBiasRd: r_state <= StBiasWr;
        StBiasWr: begin
          // b_data is only valid now, so the bias_init strobe lands with the first MAC cycle.
          r_bias_init <= 1'b1;
          r_bias      <= i_b_data;
          r_out_c     <= r_oc;
          r_t         <= '0;
          r_ic        <= '0;
          r_kr        <= '0;
          r_kc        <= '0;
          r_state     <= StMac;
        end
        StMac: begin
          if (w_last_tap) begin
            r_store <= 1'b1;
            r_addr  <= 10'(32'(r_r) * OUT_W + 32'(r_c));
            r_value <= w_sum;
            r_state <= StStore;
          end else begin
            r_t <= r_t + 16'd1;
            if (r_kc == 8'(K - 1)) begin
              r_kc <= '0;
              if (r_kr == 8'(K - 1)) begin
                r_kr <= '0;
                r_ic <= r_ic + 8'd1;
              end else begin
                r_kr <= r_kr + 8'd1;
              end
            end else begin
              r_kc <= r_kc + 8'd1;
            end
          end
        end
        StStore: begin
          r_t  <= '0;
          r_ic <= '0;
          r_kr <= '0;
          r_kc <= '0;
          if (w_last_pos) begin
            r_relu  <= 1'b1;
            r_out_c <= r_oc;
            r_state <= StRelu;
          end else begin
            if (r_c == 6'(OUT_W - 1)) begin
              r_c <= '0;
              r_r <= r_r + 6'd1;
            end else begin
              r_c <= r_c + 6'd1;
            end
            r_state <= StMac;
          end
        end
        StRelu: begin
          if (r_oc == 4'(OUT_CH - 1)) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_oc    <= r_oc + 4'd1;
            r_r     <= '0;
            r_c     <= '0;
            r_state <= StBiasRd;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_in_rd_addr = w_in_addr;
  assign o_w_rd_addr  = w_w_addr;
  assign o_b_rd_addr  = r_oc;
  assign o_bias_init  = r_bias_init;
  assign o_bias       = r_bias;
  assign o_store      = r_store;
  assign o_addr       = r_addr;
  assign o_value      = r_value;
  assign o_relu       = r_relu;
  assign o_out_c      = r_out_c;
  assign o_done       = r_done;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench: a direct-convolution model queues expected strobes, a monitor pops them.
module tb_conv_mac_sequencer;

  localparam int IN_W   = 4;
  localparam int K      = 3;
  localparam int IN_CH  = 1;
  localparam int OUT_CH = 2;
  localparam int OUT_W  = IN_W - K + 1;
  localparam int T      = IN_CH * K * K;
  localparam int P      = OUT_W * OUT_W;
  localparam int LAT    = OUT_CH * (3 + P * (T + 2)) + 1;

  localparam int EvBias  = 0;
  localparam int EvStore = 1;
  localparam int EvRelu  = 2;
  localparam int EvDone  = 3;

  typedef struct {
    int          kind;
    int          oc;
    int          addr;
    logic [31:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic [9:0]  in_rd_addr;
  logic [15:0] in_data;
  logic [9:0]  w_rd_addr;
  logic [15:0] w_data;
  logic [3:0]  b_rd_addr;
  logic [31:0] b_data;
  logic        bias_init;
  logic [31:0] bias;
  logic        store;
  logic [9:0]  addr;
  logic [31:0] value;
  logic        relu;
  logic [3:0]  out_c;
  logic        done;

  logic [15:0] in_mem [0:1023];
  logic [15:0] w_mem  [0:1023];
  logic [31:0] b_mem  [0:15];

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  cyc      = 0;

  conv_mac_sequencer #(
    .IN_W      (IN_W),
    .K         (K),
    .IN_CH     (IN_CH),
    .OUT_CH    (OUT_CH),
    .DATA_W    (16),
    .IN_ADDR_W (10),
    .W_ADDR_W  (10)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_in_rd_addr (in_rd_addr),
    .i_in_data    (in_data),
    .o_w_rd_addr  (w_rd_addr),
    .i_w_data     (w_data),
    .o_b_rd_addr  (b_rd_addr),
    .i_b_data     (b_data),
    .o_bias_init  (bias_init),
    .o_bias       (bias),
    .o_store      (store),
    .o_addr       (addr),
    .o_value      (value),
    .o_relu       (relu),
    .o_out_c      (out_c),
    .o_done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memories.
  always @(posedge clk) begin
    in_data <= in_mem[in_rd_addr];
    w_data  <= w_mem[w_rd_addr];
    b_data  <= b_mem[b_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0d (0x%08h), want %0d (0x%08h)",
                  name, cyc, act, act, exp, exp);
  endtask

  // Plain direct convolution over the loaded memories.
  task automatic build_expected();
    ev_t e;
    int  sum;
    for (int oc = 0; oc < OUT_CH; oc++) begin
      e = '{EvBias, oc, 0, b_mem[oc]};
      exp_q.push_back(e);
      for (int r = 0; r < OUT_W; r++) begin
        for (int c = 0; c < OUT_W; c++) begin
          sum = 0;
          for (int ic = 0; ic < IN_CH; ic++)
            for (int kr = 0; kr < K; kr++)
              for (int kc = 0; kc < K; kc++)
                sum += int'($signed(in_mem[ic*IN_W*IN_W + (r+kr)*IN_W + (c+kc)])) *
                       int'($signed(w_mem[((oc*IN_CH + ic)*K + kr)*K + kc]));
          e = '{EvStore, oc, r*OUT_W + c, sum};
          exp_q.push_back(e);
        end
      end
      e = '{EvRelu, oc, 0, 32'd0};
      exp_q.push_back(e);
    end
    e = '{EvDone, 0, 0, 32'd0};
    exp_q.push_back(e);
  endtask

  // mode: 0 ones, 1 px=2/w=-1, 2 max positive, 3 ramp/centre tap, 4 random
  task automatic load_mems(input int mode);
    for (int i = 0; i < 1024; i++) begin
      unique case (mode)
        0: begin in_mem[i] = 16'd1;     w_mem[i] = 16'd1;      end
        1: begin in_mem[i] = 16'd2;     w_mem[i] = 16'hFFFF;   end
        2: begin in_mem[i] = 16'd32767; w_mem[i] = 16'd32767;  end
        3: begin in_mem[i] = 16'(i);    w_mem[i] = 16'd0;      end
        default: begin in_mem[i] = 16'($urandom); w_mem[i] = 16'($urandom); end
      endcase
    end
    if (mode == 3) begin
      w_mem[4]  = 16'd1;
      w_mem[13] = 16'd1;
    end
    for (int i = 0; i < 16; i++) b_mem[i] = (mode == 4) ? $urandom : 32'(5 + i);
  endtask

  // Monitor: every strobe pops one expected event.
  logic [3:0] prev_strb = 4'd0;
  always @(negedge clk) begin
    logic [3:0] strb;
    int         kind;
    ev_t        e;
    strb = {done, relu, store, bias_init};
    if (!rst && strb != 4'd0) begin
      kind = strb[0] ? EvBias : strb[1] ? EvStore : strb[2] ? EvRelu : EvDone;
      chk("strobe_onehot", 32'($countones(strb)), 32'd1);
      chk("strobe_width", 32'(strb & prev_strb), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_kind", kind, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", kind, e.kind);
        if (e.kind == EvBias) begin
          chk("bias_value", bias, e.val);
          chk("bias_out_c", 32'(out_c), e.oc);
        end else if (e.kind == EvStore) begin
          chk("store_addr", 32'(addr), e.addr);
          chk("store_value", value, e.val);
          chk("store_out_c", 32'(out_c), e.oc);
        end else if (e.kind == EvRelu) begin
          chk("relu_out_c", 32'(out_c), e.oc);
        end
      end
    end
    prev_strb = rst ? 4'd0 : strb;
  end

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic run_layer(input bit extra_start);
    int s;
    bit seen;
    build_expected();
    pulse_start(s);
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = extra_start && (cyc == s + 30 || cyc == s + 31);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("latency", cyc - s, LAT);
      chk("busy_at_done", busy, 1'b1);
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int s;
    rst   = 1'b1;
    start = 1'b0;
    load_mems(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_value", value, 32'd0);
    chk("reset_bias", bias, 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);

    run_layer(1'b0);
    load_mems(1); run_layer(1'b0);
    load_mems(2); run_layer(1'b0);
    load_mems(3); run_layer(1'b0);
    load_mems(0); run_layer(1'b1);
    load_mems(4); run_layer(1'b0);
    load_mems(4); run_layer(1'b0);

    // Reset during channel 1's MAC must abort cleanly.
    load_mems(0);
    build_expected();
    pulse_start(s);
    repeat (54) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_strobes", 32'({bias_init, store, relu, done}), 32'd0);
    chk("midrst_bias", bias, 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_value", value, 32'd0);
    chk("midrst_out_c", 32'(out_c), 32'd0);
    chk("midrst_rd_addrs", 32'({in_rd_addr, w_rd_addr, b_rd_addr}), 32'd0);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("midrst_idle_busy", busy, 1'b0);
    run_layer(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
